key_debounce: RTL and testbench
===============================

# key_debounce

Board push-button input conditioner: the input-side counterpart of the LED output drivers. Synchronises KEY_NUM active-low mechanical keys to `clk`, debounces each key independently with a per-key filter FSM, and presents a clean level plus single-cycle press/release (and optionally long-press) strobes to downstream control logic such as LED sequencers.

## Interface
- `CLK_FREQ_HZ`, 50_000_000: `clk` frequency.
- `DEBOUNCE_MS`, 20: required stable time; DB_CYCLES = CLK_FREQ_HZ/1000*DEBOUNCE_MS; must be ≥ 2.
- `LONG_MS`, 1000: hold time for long press; LONG_CYCLES = CLK_FREQ_HZ/1000*LONG_MS; must be > DB_CYCLES.
- `KEY_NUM`, 4: number of keys.

- `clk`  input  1  system clock, 50 MHz on board.
- `rst_n`  input  1  reset; asynchronous, active-low.
- `key_n`  input  KEY_NUM  raw key pins, 0 = pressed, asynchronous to `clk`.
- `key_state`  output  KEY_NUM  debounced level, 1 = pressed.
- `key_press`  output  KEY_NUM  one-cycle strobe on debounced press.
- `key_release`  output  KEY_NUM  one-cycle strobe on debounced release.
- `key_long`  output  KEY_NUM  one-cycle strobe when held LONG_CYCLES (see Configuration).

## Operation
- Per key: 2-FF synchroniser (reset value 1 = released), then filter FSM with counter `cnt`, width $clog2(DB_CYCLES+1).
- States: IDLE (stable released), PRESS_FILT, PRESSED, RELEASE_FILT.
- IDLE: synced=0 → PRESS_FILT, cnt←0.
- PRESS_FILT: synced=1 → IDLE (bounce, no strobe); else cnt==DB_CYCLES-1 → PRESSED, key_press pulse; else cnt++.
- PRESSED: synced=1 → RELEASE_FILT, cnt←0.
- RELEASE_FILT: synced=0 → PRESSED (bounce, no strobe); else cnt==DB_CYCLES-1 → IDLE, key_release pulse; else cnt++.
- key_state = 1 in PRESSED and RELEASE_FILT, 0 otherwise (registered).
- Keys fully independent; simultaneous events on different keys produce simultaneous strobes.
- Reset (any time, mid-filter included): all FSMs → IDLE, counters 0, synchronisers 1, all outputs 0 with no strobe emitted on reset exit.

## Timing
- Raw key_n edge first sampled at edge E: synced changes after E+1; FSM leaves IDLE/PRESSED at E+2; key_state and strobe assert after edge E+2+DB_CYCLES.
- Strobes high exactly one cycle; key_state changes in the same cycle as the corresponding strobe.
- Any glitch shorter than DB_CYCLES stable cycles after synchronisation produces no output change.
- All outputs registered; no combinational path from key_n.

## Configuration
- `KEY_LONG_PRESS_EN` defined: long counter per key (width $clog2(LONG_CYCLES+1)), cleared on entry to PRESSED from PRESS_FILT, counts in PRESSED and RELEASE_FILT, saturates; key_long pulses once when it reaches LONG_CYCLES-1; at most one key_long per press; cleared in IDLE.
- Not defined: no long counter logic; key_long tied to 0. Port list unchanged.

## Structure
- Shared package `key_pkg`: state encoding localparams (IDLE=2'd0, PRESS_FILT=2'd1, PRESSED=2'd2, RELEASE_FILT=2'd3) and the ms-to-cycles constant function.
- Sub-module `key_filter`: one synchroniser + FSM + counters for a single key; top generates KEY_NUM instances.

## Test plan
Bench parameters: CLK_FREQ_HZ=1000, DEBOUNCE_MS=8 (DB_CYCLES=8), LONG_MS=32 (LONG_CYCLES=32), KEY_NUM=4.
- Clean press: key_n[0] 1→0 held 20 cycles → key_press[0] one cycle and key_state[0]=1 exactly 10 cycles after first low sample.
- Bounce: key_n[1] low 5 cycles, high 2, low 3, high → no strobes, key_state[1] stays 0.
- Release with bounce: after stable press, key_n[2] high 4 cycles, low 1, high 12 → exactly one key_release[2], none before final stable 8 cycles.
- Simultaneous: key_n[3:0] 4'b1111→4'b0000 same cycle → key_press=4'b1111 in one cycle.
- Long press (macro on): hold key 0 for 50 cycles → one key_long[0] pulse; macro off → key_long stays 0.
- Reset mid-filter: assert rst_n low during PRESS_FILT (cnt=5) → all outputs 0 immediately; after release with key held, press strobe reappears only after full E+2+DB_CYCLES.

Source files
------------

// File: rtl/key_pkg.sv
// Shared definitions for the push-button conditioner: filter FSM
// state encoding and the millisecond-to-cycle conversion.
package key_pkg;

  typedef logic [1:0] key_st_t;

  localparam key_st_t IDLE         = 2'd0;
  localparam key_st_t PRESS_FILT   = 2'd1;
  localparam key_st_t PRESSED      = 2'd2;
  localparam key_st_t RELEASE_FILT = 2'd3;

  function automatic int ms_to_cycles(
    input int freq_hz,
    input int ms
  );
    return freq_hz / 1000 * ms;
  endfunction

endpackage

// File: rtl/key_filter.sv
// Single-key conditioner: 2-FF synchroniser, debounce FSM, optional
// long-press counter (enabled by KEY_LONG_PRESS_EN).
module key_filter
  import key_pkg::*;
#(
  parameter int DB_CYCLES   = 8,
  parameter int LONG_CYCLES = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n_i,
  output logic state_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  if (DB_CYCLES < 2) begin : g_db_chk
    $error("key_filter: DB_CYCLES must be >= 2");
  end
  if (LONG_CYCLES <= DB_CYCLES) begin : g_long_chk
    $error("key_filter: LONG_CYCLES must exceed DB_CYCLES");
  end

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  key_st_t       st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          state_q, state_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      st_q    <= IDLE;
      cnt_q   <= '0;
      state_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  // Filter phases restart the count; any opposite sample is a bounce.
  always_comb begin
    sync1_d = key_n_i;
    sync2_d = sync1_q;
    st_d    = st_q;
    cnt_d   = cnt_q;
    unique case (st_q)
      IDLE: begin
        if (!sync2_q) begin
          st_d  = PRESS_FILT;
          cnt_d = '0;
        end
      end
      PRESS_FILT: begin
        if (sync2_q) st_d = IDLE;
        else if (cnt_q == CNT_LAST) st_d = PRESSED;
        else cnt_d = cnt_q + CW'(1);
      end
      PRESSED: begin
        if (sync2_q) begin
          st_d  = RELEASE_FILT;
          cnt_d = '0;
        end
      end
      RELEASE_FILT: begin
        if (!sync2_q) st_d = PRESSED;
        else if (cnt_q == CNT_LAST) st_d = IDLE;
        else cnt_d = cnt_q + CW'(1);
      end
      default: st_d = IDLE;
    endcase
  end

  always_comb begin
    press_d = (st_q == PRESS_FILT) && (st_d == PRESSED);
    rel_d   = (st_q == RELEASE_FILT) && (st_d == IDLE);
    state_d = (st_d == PRESSED) || (st_d == RELEASE_FILT);
  end

  assign state_o   = state_q;
  assign press_o   = press_q;
  assign release_o = rel_q;

`ifdef KEY_LONG_PRESS_EN
  localparam int LW = $clog2(LONG_CYCLES + 1);
  localparam logic [LW-1:0] LCNT_LAST = LW'(LONG_CYCLES - 1);
  localparam logic [LW-1:0] LCNT_PRE  = LW'(LONG_CYCLES - 2);

  logic [LW-1:0] lcnt_q, lcnt_d;
  logic          long_q, long_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lcnt_q <= '0;
      long_q <= 1'b0;
    end else begin
      lcnt_q <= lcnt_d;
      long_q <= long_d;
    end
  end

  // Saturation at the last value gives one pulse per press,
  // even across release bounces.
  always_comb begin
    lcnt_d = '0;
    long_d = 1'b0;
    if (st_q == PRESSED || st_q == RELEASE_FILT) begin
      lcnt_d = lcnt_q;
      if (lcnt_q != LCNT_LAST) begin
        lcnt_d = lcnt_q + LW'(1);
        long_d = (lcnt_q == LCNT_PRE);
      end
    end
  end

  assign long_o = long_q;
`else
  assign long_o = 1'b0;
`endif

endmodule

// File: rtl/key_debounce.sv
// Push-button conditioner: KEY_NUM independent synchronised, debounced
// keys. Long-press strobes only when KEY_LONG_PRESS_EN is defined.
module key_debounce
  import key_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter int KEY_NUM     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [KEY_NUM-1:0] key_n,
  output logic [KEY_NUM-1:0] key_state,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release,
  output logic [KEY_NUM-1:0] key_long
);

  localparam int DB_CYCLES   = ms_to_cycles(CLK_FREQ_HZ, DEBOUNCE_MS);
  localparam int LONG_CYCLES = ms_to_cycles(CLK_FREQ_HZ, LONG_MS);

  for (genvar i = 0; i < KEY_NUM; i++) begin : g_key
    key_filter #(
      .DB_CYCLES  (DB_CYCLES),
      .LONG_CYCLES(LONG_CYCLES)
    ) u_filter (
      .clk      (clk),
      .rst_n    (rst_n),
      .key_n_i  (key_n[i]),
      .state_o  (key_state[i]),
      .press_o  (key_press[i]),
      .release_o(key_release[i]),
      .long_o   (key_long[i])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce: DB_CYCLES=8, LONG_CYCLES=32.
// Key_long expectations follow KEY_LONG_PRESS_EN.
module tb_key_debounce;

  logic       clk;
  logic       rst_n;
  logic [3:0] key_n;
  logic [3:0] key_state;
  logic [3:0] key_press;
  logic [3:0] key_release;
  logic [3:0] key_long;

  int n_cmp;
  int n_err;

`ifdef KEY_LONG_PRESS_EN
  localparam int EXP_LONG_CNT = 1;
  localparam int EXP_LONG_AT  = 42;
`else
  localparam int EXP_LONG_CNT = 0;
  localparam int EXP_LONG_AT  = -1;
`endif

  key_debounce #(
    .CLK_FREQ_HZ(1000),
    .DEBOUNCE_MS(8),
    .LONG_MS    (32),
    .KEY_NUM    (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_n      (key_n),
    .key_state  (key_state),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    key_n = 4'hF;
    #2;
    n_cmp++;
    if (key_state !== 4'h0) begin
      n_err++;
      $display("FAIL reset_state got %b want 0000", key_state);
    end
    n_cmp++;
    if (key_press !== 4'h0 || key_release !== 4'h0) begin
      n_err++;
      $display("FAIL reset_strobe got %b/%b want 0000/0000",
               key_press, key_release);
    end
    n_cmp++;
    if (key_long !== 4'h0) begin
      n_err++;
      $display("FAIL reset_long got %b want 0000", key_long);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int t = 0; t < 4; t++) tick();
    n_cmp++;
    if (key_state !== 4'h0 || key_press !== 4'h0) begin
      n_err++;
      $display("FAIL reset_exit got %b/%b want 0000/0000",
               key_state, key_press);
    end
  endtask

  task automatic test_clean_press();
    int pcnt, pat, sat, rcnt, rat, other;
    pcnt = 0; pat = -1; sat = -1; other = 0;
    key_n[0] = 1'b0;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (key_press[0]) begin
        pcnt++;
        if (pat < 0) pat = t;
      end
      if (key_state[0] && sat < 0) sat = t;
      if (key_press[3:1] != 3'b0) other++;
    end
    n_cmp++;
    if (pcnt !== 1) begin
      n_err++;
      $display("FAIL clean_press_count got %0d want 1", pcnt);
    end
    n_cmp++;
    if (pat !== 11) begin
      n_err++;
      $display("FAIL clean_press_tick got %0d want 11", pat);
    end
    n_cmp++;
    if (sat !== 11) begin
      n_err++;
      $display("FAIL clean_state_tick got %0d want 11", sat);
    end
    n_cmp++;
    if (other !== 0) begin
      n_err++;
      $display("FAIL clean_other_keys got %0d want 0", other);
    end
    rcnt = 0; rat = -1;
    key_n[0] = 1'b1;
    for (int t = 1; t <= 14; t++) begin
      tick();
      if (key_release[0]) begin
        rcnt++;
        if (rat < 0) rat = t;
      end
    end
    n_cmp++;
    if (rcnt !== 1 || rat !== 11) begin
      n_err++;
      $display("FAIL clean_release got cnt=%0d at %0d want 1 at 11",
               rcnt, rat);
    end
    n_cmp++;
    if (key_state[0] !== 1'b0) begin
      n_err++;
      $display("FAIL clean_release_state got %b want 0", key_state[0]);
    end
  endtask

  task automatic test_bounce();
    int hits;
    hits = 0;
    key_n[1] = 1'b0;
    for (int t = 0; t < 5; t++) begin
      tick();
      hits += int'(key_press[1]) + int'(key_state[1]) + int'(key_release[1]);
    end
    key_n[1] = 1'b1;
    for (int t = 0; t < 2; t++) begin
      tick();
      hits += int'(key_press[1]) + int'(key_state[1]) + int'(key_release[1]);
    end
    key_n[1] = 1'b0;
    for (int t = 0; t < 3; t++) begin
      tick();
      hits += int'(key_press[1]) + int'(key_state[1]) + int'(key_release[1]);
    end
    key_n[1] = 1'b1;
    for (int t = 0; t < 14; t++) begin
      tick();
      hits += int'(key_press[1]) + int'(key_state[1]) + int'(key_release[1]);
    end
    n_cmp++;
    if (hits !== 0) begin
      n_err++;
      $display("FAIL bounce_quiet got %0d events want 0", hits);
    end
  endtask

  task automatic test_release_bounce();
    int early, dropped, rcnt, rat;
    key_n[2] = 1'b0;
    for (int t = 0; t < 12; t++) tick();
    n_cmp++;
    if (key_state[2] !== 1'b1) begin
      n_err++;
      $display("FAIL relb_pressed got %b want 1", key_state[2]);
    end
    early = 0; dropped = 0;
    key_n[2] = 1'b1;
    for (int t = 0; t < 4; t++) begin
      tick();
      early += int'(key_release[2]);
      dropped += int'(!key_state[2]);
    end
    key_n[2] = 1'b0;
    tick();
    early += int'(key_release[2]);
    dropped += int'(!key_state[2]);
    rcnt = 0; rat = -1;
    key_n[2] = 1'b1;
    for (int t = 1; t <= 14; t++) begin
      tick();
      if (key_release[2]) begin
        rcnt++;
        if (rat < 0) rat = t;
      end
      if (t < 11) dropped += int'(!key_state[2]);
    end
    n_cmp++;
    if (early !== 0) begin
      n_err++;
      $display("FAIL relb_early got %0d want 0", early);
    end
    n_cmp++;
    if (dropped !== 0) begin
      n_err++;
      $display("FAIL relb_state_drop got %0d want 0", dropped);
    end
    n_cmp++;
    if (rcnt !== 1 || rat !== 11) begin
      n_err++;
      $display("FAIL relb_release got cnt=%0d at %0d want 1 at 11",
               rcnt, rat);
    end
  endtask

  task automatic test_simultaneous();
    int full, part, at;
    full = 0; part = 0; at = -1;
    key_n = 4'h0;
    for (int t = 1; t <= 14; t++) begin
      tick();
      if (key_press == 4'hF) begin
        full++;
        if (at < 0) at = t;
      end else if (key_press != 4'h0) part++;
    end
    n_cmp++;
    if (full !== 1 || part !== 0 || at !== 11) begin
      n_err++;
      $display("FAIL simul_press got full=%0d part=%0d at %0d want 1 0 11",
               full, part, at);
    end
    full = 0; part = 0; at = -1;
    key_n = 4'hF;
    for (int t = 1; t <= 14; t++) begin
      tick();
      if (key_release == 4'hF) begin
        full++;
        if (at < 0) at = t;
      end else if (key_release != 4'h0) part++;
    end
    n_cmp++;
    if (full !== 1 || part !== 0 || at !== 11) begin
      n_err++;
      $display("FAIL simul_release got full=%0d part=%0d at %0d want 1 0 11",
               full, part, at);
    end
  endtask

  task automatic test_long_press();
    int lcnt, lat, other;
    lcnt = 0; lat = -1; other = 0;
    key_n[0] = 1'b0;
    for (int t = 1; t <= 50; t++) begin
      tick();
      if (key_long[0]) begin
        lcnt++;
        if (lat < 0) lat = t;
      end
      if (key_long[3:1] != 3'b0) other++;
    end
    key_n[0] = 1'b1;
    for (int t = 51; t <= 70; t++) begin
      tick();
      if (key_long[0]) lcnt++;
    end
    n_cmp++;
    if (lcnt !== EXP_LONG_CNT) begin
      n_err++;
      $display("FAIL long_count got %0d want %0d", lcnt, EXP_LONG_CNT);
    end
    n_cmp++;
    if (lat !== EXP_LONG_AT) begin
      n_err++;
      $display("FAIL long_tick got %0d want %0d", lat, EXP_LONG_AT);
    end
    n_cmp++;
    if (other !== 0) begin
      n_err++;
      $display("FAIL long_other_keys got %0d want 0", other);
    end
  endtask

  task automatic test_reset_mid();
    int pcnt, pat, rcnt;
    logic [3:0] pval;
    key_n[3] = 1'b0;
    for (int t = 0; t < 12; t++) tick();
    n_cmp++;
    if (key_state !== 4'b1000) begin
      n_err++;
      $display("FAIL rmid_pre_state got %b want 1000", key_state);
    end
    key_n[0] = 1'b0;
    for (int t = 0; t < 8; t++) tick();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (key_state !== 4'h0 || key_press !== 4'h0 ||
        key_release !== 4'h0) begin
      n_err++;
      $display("FAIL rmid_async got %b/%b/%b want all 0",
               key_state, key_press, key_release);
    end
    tick();
    tick();
    rst_n = 1'b1;
    pcnt = 0; pat = -1; rcnt = 0; pval = 4'h0;
    for (int t = 1; t <= 14; t++) begin
      tick();
      if (key_press != 4'h0) begin
        pcnt++;
        if (pat < 0) begin
          pat = t;
          pval = key_press;
        end
      end
      if (key_release != 4'h0) rcnt++;
    end
    n_cmp++;
    if (pcnt !== 1 || pat !== 11 || pval !== 4'b1001) begin
      n_err++;
      $display("FAIL rmid_press got cnt=%0d at %0d val=%b want 1 11 1001",
               pcnt, pat, pval);
    end
    n_cmp++;
    if (rcnt !== 0) begin
      n_err++;
      $display("FAIL rmid_release got %0d want 0", rcnt);
    end
    key_n = 4'hF;
    for (int t = 0; t < 14; t++) tick();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    key_n = 4'hF;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_bounce();
    test_simultaneous();
    test_long_press();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
